// File: rtl/rv_imem_responder.sv
// rv_imem_responder: instruction-fetch bus responder in front of a synchronous
// word-addressed SRAM with 1-cycle read latency and WAIT_STATES extra cycles.
// A one-entry last-word cache is built when IMEM_LAST_WORD_CACHE_EN is
// defined. Without that macro there is no cache and i_flush is ignored.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | sample request; issue SRAM read (or cache hit)
// S_WAIT     | extra wait states counting down after the SRAM read
// S_RESP     | SRAM data valid; ack if request still matches latched tag
// S_RESP_HIT | (cache build) ack with cached word if request still matches
`timescale 1ns/1ps

module rv_imem_responder #(
    parameter int ADDR_W      = 14,
    parameter int WAIT_STATES = 0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [31:0]       i_addr,
    input  logic              i_cyc,
    output logic [31:0]       o_instruction,
    output logic              o_ack,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_re,
    input  logic [31:0]       i_mem_rdata,
    input  logic              i_flush
);

    localparam logic [3:0] LP_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef IMEM_LAST_WORD_CACHE_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2, S_RESP_HIT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;
`endif

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_wait_cnt;
    logic [ADDR_W-1:0]   r_req_tag;
    logic [ADDR_W-1:0]   w_word;
    logic                w_hit;
    logic                w_match;

    assign w_word  = i_addr[ADDR_W+1:2];
    assign w_match = i_cyc && (w_word == r_req_tag);

`ifdef IMEM_LAST_WORD_CACHE_EN
    logic                r_c_valid;
    logic [ADDR_W-1:0]   r_c_tag;
    logic [31:0]         r_c_data;
    logic                r_nofill;
    logic                w_unused;

    // A flush in the same cycle as a lookup must not be served from the cache.
    assign w_hit    = r_c_valid && !i_flush && (r_c_tag == w_word);
    assign w_unused = &{1'b0, i_addr[31:ADDR_W+2], i_addr[1:0]};

    // Last-word cache: flush beats fill; an access that saw a flush never fills.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_c_valid <= 1'b0;
            r_c_tag   <= '0;
            r_c_data  <= '0;
            r_nofill  <= 1'b0;
        end else begin
            if (i_flush) begin
                r_c_valid <= 1'b0;
            end else if (r_state == S_RESP && o_ack && !r_nofill) begin
                r_c_valid <= 1'b1;
                r_c_tag   <= r_req_tag;
                r_c_data  <= i_mem_rdata;
            end
            r_nofill <= (r_state == S_IDLE) ? i_flush : (r_nofill | i_flush);
        end
    end
`else
    logic                w_unused;

    assign w_hit    = 1'b0;
    assign w_unused = &{1'b0, i_addr[31:ADDR_W+2], i_addr[1:0], i_flush};
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request tag and wait-state down-counter.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_req_tag  <= '0;
            r_wait_cnt <= 4'd0;
        end else if (r_state == S_IDLE && i_cyc) begin
            r_req_tag  <= w_word;
            r_wait_cnt <= LP_WAIT_LOAD;
        end else if (r_state == S_WAIT && r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_cyc) begin
`ifdef IMEM_LAST_WORD_CACHE_EN
                    if (w_hit) w_next = S_RESP_HIT;
                    else
`endif
                    if (WAIT_STATES > 0) w_next = S_WAIT;
                    else w_next = S_RESP;
                end
            end
            S_WAIT: begin
                if (!i_cyc) w_next = S_IDLE;
                else if (r_wait_cnt == 4'd0) w_next = S_RESP;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs: read strobe only from IDLE; ack only while the request still matches.
    always_comb begin
        o_mem_addr    = w_word;
        o_mem_re      = i_reset_n && (r_state == S_IDLE) && i_cyc && !w_hit;
        o_ack         = 1'b0;
        o_instruction = 32'd0;
        if (r_state == S_RESP && w_match) begin
            o_ack         = 1'b1;
            o_instruction = i_mem_rdata;
        end
`ifdef IMEM_LAST_WORD_CACHE_EN
        if (r_state == S_RESP_HIT && w_match) begin
            o_ack         = 1'b1;
            o_instruction = r_c_data;
        end
`endif
    end

endmodule

// File: tb/tb_rv_imem_responder.sv
// Bench for rv_imem_responder: directed fetch scenarios followed by randomized
// traffic, all compared cycle by cycle against a latency-based reference model.
`timescale 1ns/1ps

module tb_rv_imem_responder;

    localparam int AW = 8;
    localparam int WS = 3;
`ifdef IMEM_LAST_WORD_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   i_addr = '0;
    logic          i_cyc = 1'b0;
    logic          i_flush = 1'b0;
    logic [31:0]   o_instruction;
    logic          o_ack;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_re;
    logic [31:0]   sram_q = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;
    int re_count = 0;

    // Reference model: a request is either idle, or due to answer in m_left cycles.
    bit          m_busy = 0;
    int          m_left = 0;
    logic [AW-1:0] m_tag = '0;
    bit          m_hitsrc = 0;
    bit          m_valid = 0;
    logic [AW-1:0] m_ctag = '0;
    logic [31:0] m_cdata = '0;
    bit          m_nofill = 0;
    bit          m_ack_last = 0;

    rv_imem_responder #(.ADDR_W(AW), .WAIT_STATES(WS)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_addr(i_addr), .i_cyc(i_cyc),
        .o_instruction(o_instruction), .o_ack(o_ack), .o_mem_addr(o_mem_addr),
        .o_mem_re(o_mem_re), .i_mem_rdata(sram_q), .i_flush(i_flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [AW-1:0] a);
        return 32'h9E3779B9 * {24'd0, a} + 32'h00500093;
    endfunction

    // Synchronous SRAM, one-cycle latency, output held between reads.
    always @(posedge clk) if (o_mem_re) sram_q <= mem_val(o_mem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    task automatic tick();
        logic [AW-1:0] w;
        bit e_re, e_ack, hit, fill;
        logic [31:0] e_ins;
        @(negedge clk);
        w = i_addr[AW+1:2];
        e_re = 0; e_ack = 0; e_ins = '0; hit = 0; fill = 0;
        if (!rst_n) begin
            m_busy = 0; m_valid = 0; m_nofill = 0;
        end else if (!m_busy) begin
            hit  = CACHE_EN && m_valid && !i_flush && (m_ctag == w);
            e_re = i_cyc && !hit;
        end else if (m_left == 0) begin
            e_ack = i_cyc && (w == m_tag);
            if (e_ack) e_ins = m_hitsrc ? m_cdata : mem_val(m_tag);
        end
        check("ack", {31'd0, o_ack}, {31'd0, e_ack});
        check("mem_re", {31'd0, o_mem_re}, {31'd0, e_re});
        check("instr", o_instruction, e_ins);
        if (e_re) check("mem_addr", {24'd0, o_mem_addr}, {24'd0, w});
        re_count += int'(o_mem_re);
        m_ack_last = e_ack;
        if (rst_n) begin
            fill = m_busy && m_left == 0 && e_ack && !m_hitsrc && !i_flush && !m_nofill;
            if (i_flush) m_valid = 0;
            else if (CACHE_EN && fill) begin
                m_valid = 1; m_ctag = m_tag; m_cdata = mem_val(m_tag);
            end
            if (!m_busy) begin
                m_nofill = i_flush;
                if (i_cyc) begin
                    m_busy = 1; m_tag = w; m_hitsrc = hit; m_left = hit ? 0 : WS;
                end
            end else if (m_left > 0) begin
                m_nofill = m_nofill | i_flush;
                if (!i_cyc) m_busy = 0;
                else m_left--;
            end else begin
                m_busy = 0;
            end
        end
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    // Hold a request until acked (bounded), then drop i_cyc for one cycle.
    task automatic fetch(input logic [31:0] a, output int lat, output int nre);
        int t0;
        bit done;
        i_addr = a; i_cyc = 1'b1;
        t0 = cyc_n; re_count = 0; done = 0; lat = -1;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            if (m_ack_last) begin done = 1; lat = cyc_n - 1 - t0; end
        end
        if (!done) check("fetch_timeout", 32'd0, 32'd1);
        nre = re_count;
        i_cyc = 1'b0;
        tick();
    endtask

    initial begin
        int lat, nre, t0, nacks;
        int ack_t[3];
        logic [31:0] tmp;

        repeat (2) @(posedge clk);
        #1;
        tick();
        rst_n = 1'b1;
        tick();

        // Halfword-aligned address returns the aligned word SRAM[0x10].
        fetch(32'h42, lat, nre);
        check("lat_0x42", lat, WS + 1);
        check("re_0x42", nre, 1);

        // Sequential fetch with i_cyc held; address advances after each ack.
        i_addr = 32'h0; i_cyc = 1'b1; t0 = cyc_n; re_count = 0; nacks = 0;
        for (int k = 0; k < 60 && nacks < 3; k++) begin
            tick();
            if (m_ack_last) begin
                ack_t[nacks] = cyc_n - 1 - t0;
                nacks++;
                if (nacks == 3) i_cyc = 1'b0;
                else i_addr = i_addr + 32'd4;
            end
        end
        check("seq_nacks", nacks, 3);
        check("seq_ack0", ack_t[0], WS + 1);
        check("seq_ack1", ack_t[1], 2 * WS + 3);
        check("seq_ack2", ack_t[2], 3 * WS + 5);
        check("seq_re", re_count, 3);
        tick();

        // Redirect during WAIT: the 0x100 read is discarded, 0x200 re-read.
        i_addr = 32'h100; i_cyc = 1'b1; t0 = cyc_n; nacks = 0; lat = -1;
        tick();
        i_addr = 32'h200;
        for (int k = 0; k < 40 && nacks == 0; k++) begin
            tick();
            if (m_ack_last) begin nacks = 1; lat = cyc_n - 1 - t0; end
        end
        check("redirect_lat", lat, 2 * WS + 3);
        i_cyc = 1'b0;
        tick();

        // Drop i_cyc in WAIT, then reset during a RESP cycle.
        i_addr = 32'h40; i_cyc = 1'b1;
        tick();
        i_cyc = 1'b0;
        repeat (3) tick();
        i_cyc = 1'b1;
        repeat (WS + 1) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        i_cyc = 1'b0;
        tick();

`ifdef IMEM_LAST_WORD_CACHE_EN
        fetch(32'h40, lat, nre);
        check("cache_miss_lat", lat, WS + 1);
        fetch(32'h40, lat, nre);
        check("cache_hit_lat", lat, 1);
        check("cache_hit_re", nre, 0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        fetch(32'h40, lat, nre);
        check("flush_lat", lat, WS + 1);
        check("flush_re", nre, 1);
`endif

        // Randomized traffic: sequential/aliased addresses, aborts, redirects, flushes, resets.
        i_cyc = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (!rst_n) rst_n = 1'b1;
            else if (r < 1) rst_n = 1'b0;
            if (m_ack_last || !i_cyc || (r >= 6 && r < 10)) begin
                if ($urandom_range(0, 2) == 0 || (r >= 6 && r < 10)) begin
                    tmp = $urandom();
                    i_addr = (tmp & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
                end else begin
                    i_addr = i_addr + 32'd4;
                end
            end
            i_cyc   = !(r >= 1 && r < 6);
            i_flush = (r >= 96);
            tick();
        end
        i_cyc = 1'b0; i_flush = 1'b0; rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv_imem_responder.md
Name: rv_imem_responder

Overview:
Responder end of the core's instruction-fetch bus: accepts address/cycle requests from the fetch stage and returns one aligned 32-bit word with a single-cycle ack. Backs onto a synchronous word-addressed instruction SRAM with 1-cycle read latency, plus programmable extra wait states. Sits between the core fetch port and the instruction memory macro.

Parameters:
ADDR_W, 14, SRAM word-address width (depth = 2**ADDR_W words)
WAIT_STATES, 0, extra cycles inserted between SRAM read and ack (0..15)

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_addr  in  32  fetch byte address; bits [1:0] ignored, bits above ADDR_W+1 ignored (aliasing)
i_cyc  in  1  fetch request valid; held while waiting
o_instruction  out  32  aligned word at i_addr[ADDR_W+1:2]; valid only while o_ack=1
o_ack  out  1  one-cycle response strobe
o_mem_addr  out  ADDR_W  SRAM word address
o_mem_re  out  1  SRAM read enable (one cycle per read)
i_mem_rdata  in  32  SRAM read data, valid cycle after o_mem_re, held until next o_mem_re
i_flush  in  1  invalidate (fence.i); see Optional Feature

Behaviour:
- Reset (async, i_reset_n=0): state=IDLE, o_ack=0, o_mem_re=0, wait counter=0, latched tag=0, o_instruction=0.
- Halfword misalignment handled by the fetch stage; responder always returns the aligned word.
- States: IDLE, WAIT, RESP.
- IDLE: if i_cyc=1: o_mem_re=1 (combinational), o_mem_addr=i_addr[ADDR_W+1:2], latch word address into req_tag; go to WAIT if WAIT_STATES>0 (counter loads WAIT_STATES-1), else RESP. If i_cyc=0: o_mem_re=0, stay IDLE.
- WAIT: counter decrements; at 0 go RESP. o_mem_re=0.
- RESP: o_ack=1 only if i_cyc=1 and i_addr[ADDR_W+1:2]==req_tag; o_instruction=i_mem_rdata. Always return to IDLE next cycle.
- Latency: request seen in IDLE at cycle T -> ack at T+1+WAIT_STATES. Throughput: one word per 2+WAIT_STATES cycles (IDLE re-samples the post-ack updated address).
- o_instruction forced to 0 whenever o_ack=0.
- Abort, i_cyc dropped in WAIT: return to IDLE immediately, no ack, no further read.
- Abort in RESP (i_cyc=0 or address mismatch, e.g. branch redirect): no ack; IDLE next cycle, then re-issues for the current address. Stale data never acked.
- Address change during WAIT: access completes to RESP, where the mismatch rule suppresses ack.
- o_mem_re is never asserted outside IDLE; at most one SRAM read outstanding.
- Reset asserted mid-access: immediate return to reset state; no ack in the following cycle.

Optional Feature:
IMEM_LAST_WORD_CACHE_EN
- Defined: one-entry cache (valid, tag[ADDR_W-1:0], data[31:0]). Filled in every RESP cycle where ack issued. IDLE with i_cyc=1 and valid and tag hit: no o_mem_re, go RESP_HIT state; RESP_HIT acks with cached data next cycle (latency T+1 regardless of WAIT_STATES) subject to the same cyc/address match rule, then IDLE. i_flush=1 clears valid (async reset also clears); flush in same cycle as a fill: flush wins. An access in flight during flush completes normally but does not fill.
- Undefined: no cache, no RESP_HIT state; i_flush is ignored.

Test Plan:
- WAIT_STATES=0, SRAM[0x10]=0x00500093, i_cyc=1, i_addr=0x40 -> o_mem_re=1 with o_mem_addr=0x10 at T, o_ack=1 with o_instruction=0x00500093 at T+1, o_ack=0 at T+2.
- WAIT_STATES=3, sequential fetch 0x0,0x4,0x8 with i_cyc held -> acks at T+4, T+9, T+14; exactly 3 o_mem_re pulses.
- i_addr=0x42 (halfword aligned) -> o_mem_addr=0x10, returns full word SRAM[0x10] unchanged.
- WAIT_STATES=2, request 0x100, change i_addr to 0x200 during WAIT -> no ack for 0x100; re-read at o_mem_addr=0x80, ack with SRAM[0x80].
- i_cyc dropped in WAIT, reset pulsed in RESP -> no o_ack, state IDLE, o_instruction=0.
- IMEM_LAST_WORD_CACHE_EN, WAIT_STATES=4: fetch 0x40 twice -> second ack 1 cycle after request with no o_mem_re; pulse i_flush, fetch 0x40 again -> o_mem_re issued, ack at T+5.
